perf_counter_ctrl: RTL and testbench

//  Controller for a bank of rising-edge event counters (stalls, cache misses,

---
 rtl/perf_counter_ctrl.sv | 115 +++++++++++
 tb/tb_perf_counter_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_ctrl.sv
// Bank of rising-edge event counters with a memory-mapped control/status port.
// Handshake: request accepted in IDLE, one-cycle mem_resp, then wait for release.
module perf_counter_ctrl #(
   parameter int unsigned NUM_CTR   = 8,
   parameter int unsigned CTR_WIDTH = 16,
   parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_CTR-1:0] event_in,
   input  logic [15:0]        mem_address,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [15:0]        mem_wdata,
   output logic [15:0]        mem_rdata,
   output logic               mem_resp,
   output logic               hit
);

   localparam logic [15:0] CTRL_OFF = 16'(2 * NUM_CTR);
   localparam logic [15:0] STAT_OFF = 16'(2 * NUM_CTR + 2);

   typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_WAIT} state_t;

   state_t               state_q, state_d;
   logic [CTR_WIDTH-1:0] ctr_q [NUM_CTR];
   logic [CTR_WIDTH-1:0] ctr_d [NUM_CTR];
   logic [NUM_CTR-1:0]   prev_q, prev_d;
   logic [NUM_CTR-1:0]   stat_q, stat_d;
   logic                 en_q, en_d;
   logic [15:0]          rdata_q, rdata_d;

   logic [15:0]          off;
   logic                 is_ctr, is_ctrl, is_stat;
   logic                 accept, do_wr, do_rd, clear_all;
   logic [NUM_CTR-1:0]   inc;
   logic [15:0]          rd_val;

   // An address below BASE wraps to a large offset and so never decodes.
   assign off     = mem_address - BASE_ADDR;
   assign hit     = (off[0] == 1'b0) && (off <= STAT_OFF);
   assign is_ctr  = hit && (off < CTRL_OFF);
   assign is_ctrl = hit && (off == CTRL_OFF);
   assign is_stat = hit && (off == STAT_OFF);

   assign accept    = (state_q == ST_IDLE) && hit && (mem_read || mem_write);
   assign do_wr     = accept && mem_write;
   assign do_rd     = accept && !mem_write;
   assign clear_all = do_wr && is_ctrl && mem_wdata[1];
   assign inc       = event_in & ~prev_q & {NUM_CTR{en_q}};

   assign mem_resp  = (state_q == ST_RESP);
   assign mem_rdata = rdata_q;

   always_comb begin
      prev_d = event_in;
      en_d   = en_q;
      stat_d = stat_q;
      if (do_wr && is_ctrl) en_d = mem_wdata[0];
      if (do_wr && is_stat) stat_d = stat_q & ~mem_wdata[NUM_CTR-1:0];
      // Per counter: clear_all beats a direct write, which beats an edge.
      for (int i = 0; i < NUM_CTR; i++) begin
         ctr_d[i] = ctr_q[i];
         if (clear_all) begin
            ctr_d[i] = '0;
         end else if (do_wr && is_ctr && (off[15:1] == 15'(i))) begin
            ctr_d[i] = mem_wdata[CTR_WIDTH-1:0];
         end else if (inc[i]) begin
            ctr_d[i] = ctr_q[i] + 1'b1;
            if (&ctr_q[i]) stat_d[i] = 1'b1;
         end
      end
      if (clear_all) stat_d = '0;
   end

   always_comb begin
      rd_val = '0;
      if (is_ctrl) rd_val = {15'd0, en_q};
      if (is_stat) rd_val = 16'(stat_q);
      for (int i = 0; i < NUM_CTR; i++) begin
         if (is_ctr && (off[15:1] == 15'(i))) rd_val = 16'(ctr_q[i]);
      end
      rdata_d = do_rd ? rd_val : rdata_q;
   end

   // WAIT holds off a second execution while the requester still asserts its strobe.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_RESP;
         ST_RESP: state_d = ST_WAIT;
         ST_WAIT: if (!mem_read && !mem_write) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         prev_q  <= '0;
         stat_q  <= '0;
         en_q    <= 1'b1;
         rdata_q <= '0;
         for (int i = 0; i < NUM_CTR; i++) ctr_q[i] <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         stat_q  <= stat_d;
         en_q    <= en_d;
         rdata_q <= rdata_d;
         for (int i = 0; i < NUM_CTR; i++) ctr_q[i] <= ctr_d[i];
      end
   end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed bench for perf_counter_ctrl: register-access table plus hand-written
// sequences for edge detection, wrap/overflow, priority, reset abort and handshake.
module tb_perf_counter_ctrl;

   localparam int          NUM_CTR   = 8;
   localparam int          CTR_WIDTH = 16;
   localparam logic [15:0] BASE      = 16'hFF00;
   localparam logic [15:0] CTRL_A    = 16'hFF10;
   localparam logic [15:0] STAT_A    = 16'hFF12;

   logic               clk, rst;
   logic [NUM_CTR-1:0] event_in;
   logic [15:0]        mem_address, mem_wdata, mem_rdata;
   logic               mem_read, mem_write, mem_resp, hit;

   perf_counter_ctrl #(
      .NUM_CTR(NUM_CTR), .CTR_WIDTH(CTR_WIDTH), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst), .event_in(event_in),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .hit(hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] addr;
      logic        wr;
      logic [15:0] wdata;
      logic        exp_hit;
      logic        exp_resp;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Called at a falling edge; returns at a falling edge with the FSM back in IDLE.
   task automatic access(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                         output logic resp_seen, output logic [15:0] rdata, output int lat);
      mem_address = addr;
      mem_wdata   = wdata;
      mem_write   = wr;
      mem_read    = !wr;
      resp_seen   = 1'b0;
      rdata       = '0;
      lat         = 0;
      for (int c = 1; c <= 4 && !resp_seen; c++) begin
         @(negedge clk);
         if (mem_resp) begin
            resp_seen = 1'b1;
            rdata     = mem_rdata;
            lat       = c;
         end
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic rd_check(input string name, input logic [15:0] addr, input logic [15:0] exp);
      logic        r;
      logic [15:0] d;
      int          l;
      access(addr, 1'b0, 16'h0, r, d, l);
      check({name, "_resp"}, 32'(r), 32'd1);
      check({name, "_lat"}, 32'(l), 32'd1);
      check(name, 32'(d), 32'(exp));
   endtask

   task automatic wr_do(input string name, input logic [15:0] addr, input logic [15:0] data);
      logic        r;
      logic [15:0] d;
      int          l;
      access(addr, 1'b1, data, r, d, l);
      check({name, "_resp"}, 32'(r), 32'd1);
   endtask

   task automatic pulse(input logic [NUM_CTR-1:0] mask);
      event_in = mask;
      @(negedge clk);
      event_in = '0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      event_in  = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic        r;
      logic [15:0] d;
      int          l;
      int          cnt;

      mem_address = BASE;
      mem_wdata   = '0;
      do_reset();
      check("rst_resp", 32'(mem_resp), 32'd0);
      check("rst_rdata", 32'(mem_rdata), 32'd0);
      check("rst_hit_base", 32'(hit), 32'd1);

      // addr, wr, wdata, exp_hit, exp_resp, exp_rdata
      vecs[0]  = '{BASE,     1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000};
      vecs[1]  = '{CTRL_A,   1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001};
      vecs[2]  = '{STAT_A,   1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000};
      vecs[3]  = '{16'hFF0A, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h0000};
      vecs[4]  = '{16'hFF0A, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234};
      vecs[5]  = '{16'hFF0E, 1'b1, 16'hBEEF, 1'b1, 1'b1, 16'h0000};
      vecs[6]  = '{16'hFF0E, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hBEEF};
      vecs[7]  = '{16'hFF0A, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234};
      vecs[8]  = '{CTRL_A,   1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000};
      vecs[9]  = '{CTRL_A,   1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000};
      vecs[10] = '{CTRL_A,   1'b1, 16'h0001, 1'b1, 1'b1, 16'h0000};
      vecs[11] = '{CTRL_A,   1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001};
      vecs[12] = '{16'hFF14, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
      vecs[13] = '{16'hFF01, 1'b1, 16'h00FF, 1'b0, 1'b0, 16'h0000};

      for (int i = 0; i < 14; i++) begin
         mem_address = vecs[i].addr;
         #1;
         check($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
         access(vecs[i].addr, vecs[i].wr, vecs[i].wdata, r, d, l);
         check($sformatf("vec%0d_resp", i), 32'(r), 32'(vecs[i].exp_resp));
         if (vecs[i].exp_resp) check($sformatf("vec%0d_lat", i), 32'(l), 32'd1);
         if (vecs[i].exp_resp && !vecs[i].wr)
            check($sformatf("vec%0d_rdata", i), 32'(d), 32'(vecs[i].exp_rdata));
      end

      // Three single-cycle pulses count three edges.
      do_reset();
      repeat (3) pulse(8'h01);
      rd_check("t1_ctr0", BASE, 16'd3);

      // A held level counts once and re-arms after one low cycle.
      event_in = 8'h04;
      repeat (10) @(negedge clk);
      rd_check("t2_held", 16'hFF04, 16'd1);
      event_in = 8'h00;
      @(negedge clk);
      event_in = 8'h04;
      repeat (2) @(negedge clk);
      event_in = 8'h00;
      rd_check("t2_rearm", 16'hFF04, 16'd2);

      // Wrap to zero sets the sticky bit; W1C clears it.
      wr_do("t3_wr_ctr1", 16'hFF02, 16'hFFFF);
      pulse(8'h02);
      rd_check("t3_ctr1_wrap", 16'hFF02, 16'd0);
      rd_check("t3_stat", STAT_A, 16'h0002);
      wr_do("t3_w1c", STAT_A, 16'h0002);
      rd_check("t3_stat_clr", STAT_A, 16'h0000);

      // Direct write beats a same-cycle edge; clear_all zeroes counters and STAT.
      wr_do("t4_wr_ctr4", 16'hFF08, 16'hFFFF);
      pulse(8'h10);
      rd_check("t4_stat_pre", STAT_A, 16'h0010);
      event_in = 8'h08;
      wr_do("t4_wr_ctr3", 16'hFF06, 16'd5);
      event_in = 8'h00;
      rd_check("t4_ctr3", 16'hFF06, 16'd5);
      wr_do("t4_clear", CTRL_A, 16'h0003);
      rd_check("t4_ctr0_clr", BASE, 16'd0);
      rd_check("t4_ctr2_clr", 16'hFF04, 16'd0);
      rd_check("t4_ctr3_clr", 16'hFF06, 16'd0);
      rd_check("t4_stat_clr", STAT_A, 16'h0000);
      rd_check("t4_ctrl", CTRL_A, 16'h0001);

      // Disabled counting ignores edges; re-enable resumes.
      wr_do("t5_wr_ctr6", 16'hFF0C, 16'd7);
      wr_do("t5_disable", CTRL_A, 16'h0000);
      pulse(8'hFF);
      rd_check("t5_ctr6_hold", 16'hFF0C, 16'd7);
      rd_check("t5_ctr0_hold", BASE, 16'd0);
      wr_do("t5_enable", CTRL_A, 16'h0001);
      pulse(8'h01);
      rd_check("t5_ctr0_resume", BASE, 16'd1);

      // Reset right after the accept edge aborts the read.
      mem_address = BASE;
      mem_read    = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      cnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (mem_resp) cnt++;
      end
      mem_read = 1'b0;
      rst      = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (mem_resp) cnt++;
      end
      check("t5_abort_resp", 32'(cnt), 32'd0);
      check("t5_abort_rdata", 32'(mem_rdata), 32'd0);
      rd_check("t5_ctr6_rst", 16'hFF0C, 16'd0);

      // A strobe held long after the response yields exactly one response.
      mem_address = BASE;
      mem_read    = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (mem_resp) cnt++;
      end
      mem_read = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_single_resp", 32'(cnt), 32'd1);

      // Address just below BASE belongs to another slave.
      mem_address = BASE - 16'd2;
      mem_read    = 1'b1;
      #1;
      check("t6_hit_below", 32'(hit), 32'd0);
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (mem_resp) cnt++;
      end
      mem_read = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_no_resp", 32'(cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
